// File: rtl/vga_output_stage_if.sv
`default_nettype none
// ============================================================================
// vga_output_stage_if
// Pixel timing, colour and reduced-output bundle for vga_output_stage.
// Revision: 1.0
// ============================================================================
interface vga_output_stage_if #(
    parameter int W_IN_RED   = 5,
    parameter int W_IN_GREEN = 6,
    parameter int W_IN_BLUE  = 5,
    parameter int W_OUT      = 2
);
    logic                  pixel_ce;
    logic [1:0]            mode;
    logic                  hsync_in;
    logic                  vsync_in;
    logic                  display_on;
    logic [9:0]            hpos;
    logic [9:0]            vpos;
    logic [W_IN_RED-1:0]   red_in;
    logic [W_IN_GREEN-1:0] green_in;
    logic [W_IN_BLUE-1:0]  blue_in;
    logic                  vga_hsync;
    logic                  vga_vsync;
    logic [W_OUT-1:0]      vga_red;
    logic [W_OUT-1:0]      vga_green;
    logic [W_OUT-1:0]      vga_blue;
    logic [1:0]            mode_active;

    modport master (
        output pixel_ce, mode, hsync_in, vsync_in, display_on, hpos, vpos,
               red_in, green_in, blue_in,
        input  vga_hsync, vga_vsync, vga_red, vga_green, vga_blue, mode_active
    );

    modport slave (
        input  pixel_ce, mode, hsync_in, vsync_in, display_on, hpos, vpos,
               red_in, green_in, blue_in,
        output vga_hsync, vga_vsync, vga_red, vga_green, vga_blue, mode_active
    );
endinterface
`default_nettype wire

// File: rtl/vga_output_stage.sv
`default_nettype none
// ============================================================================
// vga_output_stage
// Two-stage colour depth reducer (truncate / MSB+OR / ordered dither) with
// latency-matched sync outputs and frame-aligned mode switching.
// Revision: 1.0
// ============================================================================
module vga_output_stage_channel #(
    parameter int W     = 5,
    parameter int W_OUT = 2
) (
    input  wire logic             clock,
    input  wire logic             reset,
    input  wire logic             pixel_ce,
    input  wire logic [3:0]       bayer,
    input  wire logic [W-1:0]     c_in,
    input  wire logic [1:0]       mode_s1,
    input  wire logic             disp_s1,
    output logic      [W_OUT-1:0] c_out
);
    localparam int c_S = W - W_OUT;

    logic [W-1:0]     r_c;
    logic [c_S-1:0]   r_t;
    logic [W_OUT-1:0] r_out;
    logic [c_S-1:0]   w_t;
    logic [W_OUT-1:0] w_top;
    logic [c_S-1:0]   w_low;
    logic [W_OUT-1:0] w_msb_or;
    logic [W_OUT-1:0] w_dith;
    logic [W_OUT-1:0] w_out;
    logic             w_up;

    // Scale the 4-bit Bayer entry onto the range of the discarded low bits
    if (c_S > 4) begin : g_thr_shl
        assign w_t = {bayer, {(c_S-4){1'b0}}};
    end else if (c_S == 4) begin : g_thr_eq
        assign w_t = bayer;
    end else begin : g_thr_shr
        assign w_t = bayer[3:4-c_S];
    end

    if (W_OUT == 1) begin : g_or_all
        assign w_msb_or = |r_c;
    end else begin : g_or_low
        assign w_msb_or = {r_c[W-1:W-W_OUT+1], |r_c[W-W_OUT:0]};
    end

    assign w_top  = r_c[W-1:c_S];
    assign w_low  = r_c[c_S-1:0];
    assign w_up   = (w_low > r_t);
    assign w_dith = (&w_top) ? w_top : w_top + W_OUT'(w_up);

    always_comb begin
        w_out = '0;
        if (disp_s1) begin
            case (mode_s1)
                2'd0:    w_out = w_top;
                2'd1:    w_out = w_msb_or;
                default: w_out = w_dith;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_c   <= '0;
            r_t   <= '0;
            r_out <= '0;
        end else if (pixel_ce) begin
            r_c   <= c_in;
            r_t   <= w_t;
            r_out <= w_out;
        end
    end

    assign c_out = r_out;
endmodule

module vga_output_stage #(
    parameter int W_IN_RED   = 5,
    parameter int W_IN_GREEN = 6,
    parameter int W_IN_BLUE  = 5,
    parameter int W_OUT      = 2
) (
    input  wire logic             clock,
    input  wire logic             reset,
    vga_output_stage_if.slave     bus
);
    if (W_OUT < 1 || W_OUT >= W_IN_RED || W_OUT >= W_IN_GREEN || W_OUT >= W_IN_BLUE)
    begin : g_bad_width
        $error("vga_output_stage: W_OUT must satisfy 1 <= W_OUT < every input width");
    end

    logic [1:0] r_mode_active;
    logic [1:0] r_frame;
    logic       r_hs1, r_vs1, r_de1;
    logic [1:0] r_mode1;
    logic       r_hs2, r_vs2;

    logic       w_frame_start;
    logic [1:0] w_mode_eff;
    logic [1:0] w_frame_eff;
    logic [1:0] w_xi, w_yi;
    logic [3:0] w_bayer;

    function automatic logic [3:0] f_bayer(input logic [1:0] y, input logic [1:0] x);
        case ({y, x})
            4'h0: f_bayer = 4'd0;   4'h1: f_bayer = 4'd8;
            4'h2: f_bayer = 4'd2;   4'h3: f_bayer = 4'd10;
            4'h4: f_bayer = 4'd12;  4'h5: f_bayer = 4'd4;
            4'h6: f_bayer = 4'd14;  4'h7: f_bayer = 4'd6;
            4'h8: f_bayer = 4'd3;   4'h9: f_bayer = 4'd11;
            4'hA: f_bayer = 4'd1;   4'hB: f_bayer = 4'd9;
            4'hC: f_bayer = 4'd15;  4'hD: f_bayer = 4'd7;
            4'hE: f_bayer = 4'd13;  default: f_bayer = 4'd5;
        endcase
    endfunction

    // The first pixel of a frame already sees the new mode and frame count
    assign w_frame_start = bus.pixel_ce & (bus.hpos == 10'd0) & (bus.vpos == 10'd0);
    assign w_mode_eff    = w_frame_start ? bus.mode : r_mode_active;
    assign w_frame_eff   = w_frame_start ? r_frame + 2'd1 : r_frame;
    assign w_xi          = (w_mode_eff == 2'd3) ? bus.hpos[1:0] + w_frame_eff : bus.hpos[1:0];
    assign w_yi          = (w_mode_eff == 2'd3) ? bus.vpos[1:0] + w_frame_eff : bus.vpos[1:0];
    assign w_bayer       = f_bayer(w_yi, w_xi);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mode_active <= 2'd0;
            r_frame       <= 2'd0;
            r_hs1         <= 1'b0;
            r_vs1         <= 1'b0;
            r_de1         <= 1'b0;
            r_mode1       <= 2'd0;
            r_hs2         <= 1'b0;
            r_vs2         <= 1'b0;
        end else if (bus.pixel_ce) begin
            r_mode_active <= w_mode_eff;
            r_frame       <= w_frame_eff;
            r_hs1         <= bus.hsync_in;
            r_vs1         <= bus.vsync_in;
            r_de1         <= bus.display_on;
            r_mode1       <= w_mode_eff;
            r_hs2         <= r_hs1;
            r_vs2         <= r_vs1;
        end
    end

    vga_output_stage_channel #(.W(W_IN_RED), .W_OUT(W_OUT)) u_red (
        .clock(clock), .reset(reset), .pixel_ce(bus.pixel_ce), .bayer(w_bayer),
        .c_in(bus.red_in), .mode_s1(r_mode1), .disp_s1(r_de1), .c_out(bus.vga_red)
    );

    vga_output_stage_channel #(.W(W_IN_GREEN), .W_OUT(W_OUT)) u_green (
        .clock(clock), .reset(reset), .pixel_ce(bus.pixel_ce), .bayer(w_bayer),
        .c_in(bus.green_in), .mode_s1(r_mode1), .disp_s1(r_de1), .c_out(bus.vga_green)
    );

    vga_output_stage_channel #(.W(W_IN_BLUE), .W_OUT(W_OUT)) u_blue (
        .clock(clock), .reset(reset), .pixel_ce(bus.pixel_ce), .bayer(w_bayer),
        .c_in(bus.blue_in), .mode_s1(r_mode1), .disp_s1(r_de1), .c_out(bus.vga_blue)
    );

    assign bus.vga_hsync   = r_hs2;
    assign bus.vga_vsync   = r_vs2;
    assign bus.mode_active = r_mode_active;
endmodule
`default_nettype wire
